axis_video_frame_checker: RTL and testbench
===========================================

AXIS_VIDEO_FRAME_CHECKER -- requirements
Module: axis_video_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning pixel tdata width (RGB, 8 bits per component).
REQ-002 SHALL have parameter CNT_W, default 12, meaning width of the pixel, line and frame counters.
REQ-003 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port areset  in  1  reset, synchronous to aclk, active-high.
REQ-005 SHALL have ports s_axis_tdata/tuser/tlast/tvalid  in  DATA_W/1/1/1  upstream video stream (tuser=SOF, tlast=EOL).
REQ-006 SHALL have port s_axis_tready  out  1  upstream backpressure.
REQ-007 SHALL have ports m_axis_tdata/tuser/tlast/tvalid  out  DATA_W/1/1/1  forwarded video stream; m_axis_tready  in  1.
REQ-008 SHALL have ports cfg_width, cfg_height  in  CNT_W each  expected active width and height (e.g. 800, 600); sampled only at SOF.
REQ-009 SHALL have ports meas_width, meas_height  out  CNT_W each  beats in last closed line, lines in last closed frame.
REQ-010 SHALL have ports frame_done  out  1  one-cycle pulse when a frame closes; frame_ok  out  1  valid with frame_done.
REQ-011 SHALL have ports err_line_short, err_line_long, err_frame_short, err_no_sof  out  1 each  sticky error flags.
REQ-012 SHALL have port frame_count  out  CNT_W  closed frames, wraps at 2^CNT_W.

Function
REQ-013 SHALL forward every accepted s_axis beat unmodified, in order, to m_axis; no beats dropped, duplicated or generated.
REQ-014 SHALL implement the datapath as a 2-entry skid buffer: 1-cycle latency s->m; s_axis_tready = not full; full throughput with m_axis_tready=1.
REQ-015 SHALL hold m_axis payload stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 SHALL measure on s_axis handshake (tvalid&tready) only; stalls and bubbles never change counters.
REQ-017 SHALL have FSM states WAIT_SOF and IN_FRAME; reset state WAIT_SOF.
REQ-018 WAIT_SOF: beat with tuser=1 -> latch cfg_width/cfg_height, pix_cnt=1 (or close line if tlast also 1), line_cnt=0, go IN_FRAME.
REQ-019 WAIT_SOF: beat with tuser=0 -> set err_no_sof, forward beat, stay WAIT_SOF.
REQ-020 IN_FRAME beat tlast=0, tuser=0: pix_cnt+1; when pix_cnt reaches latched width without tlast, set err_line_long on that beat.
REQ-021 IN_FRAME beat tlast=1: meas_width=pix_cnt+1; set err_line_short if <width, err_line_long if >width; pix_cnt=0; line_cnt+1.
REQ-022 tlast beat where line_cnt+1 == latched height -> frame_done, meas_height=line_cnt+1, frame_count+1, go WAIT_SOF.
REQ-023 IN_FRAME beat tuser=1 (premature SOF) -> close current frame: frame_done, meas_height=line_cnt, set err_frame_short, then apply REQ-018 to same beat (stay IN_FRAME).
REQ-024 frame_ok SHALL be 1 only if no line error and no err_frame_short occurred within that frame (per-frame flag, distinct from stickies).
REQ-025 pix_cnt and line_cnt SHALL saturate at 2^CNT_W-1; latched cfg value 0 treated as "no check" for that dimension.
REQ-026 Sticky flags SHALL clear only on areset.

Reset
REQ-027 areset=1 SHALL on next edge: FSM=WAIT_SOF, skid empty, m_axis_tvalid=0, s_axis_tready=0 while areset=1, all counters/meas/flags/frame_count=0, frame_done=0, frame_ok=0.
REQ-028 areset mid-frame SHALL discard buffered beats; first post-reset beat without tuser sets err_no_sof.
REQ-029 s_axis_tready SHALL go 1 on the first cycle after areset deasserts.

Structure
REQ-030 SHALL place the state enum (WAIT_SOF, IN_FRAME) and default DATA_W/CNT_W constants in shared package video_chk_pkg.
REQ-031 SHALL instantiate one sub-module axis_skid_buf (parameter W = DATA_W+2) for the datapath; measurement logic stays in top.

Verification
REQ-032 cfg 8x4, four clean 8x4 frames, m_axis_tready=1 -> 4 frame_done pulses, frame_ok=1 each, meas 8/4, frame_count=4, no flags, output == input.
REQ-033 cfg 8x4, line 2 has tlast at beat 6 -> err_line_short=1, meas_width=6, frame_ok=0 for that frame only.
REQ-034 cfg 8x4, SOF after 2 lines -> frame_done on SOF beat, meas_height=2, err_frame_short=1, next 8x4 frame frame_ok=1.
REQ-035 random tvalid gaps and m_axis_tready 50% duty -> zero data loss, payload stable under stall, same meas as REQ-032.
REQ-036 3 beats without tuser after reset, then clean frame -> err_no_sof=1, that frame frame_ok=1.
REQ-037 cfg 800x600, one full RGB frame -> meas 800/600, frame_ok=1; areset mid-line -> all outputs zero next cycle.

Source files
------------

// File: rtl/video_chk_pkg.sv
// rtl/video_chk_pkg.sv - shared constants and state type for the video frame checker
package video_chk_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int CNT_W_DEF  = 12;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } chk_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry registered skid buffer for a valid/ready stream
module axis_skid_buf #(
  parameter int W = 26
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         s_fire;
  logic         m_fire;

  // Ready depends only on occupancy, so upstream never sees a combinational path from m_tready.
  assign s_tready = (count != 2'd2) & ~areset;
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign s_fire   = s_tvalid & s_tready;
  assign m_fire   = m_tvalid & m_tready;

  // Pointer and occupancy tracking; the head entry is never overwritten while it is presented.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (s_fire) wr_ptr <= ~wr_ptr;
      if (m_fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, s_fire} - {1'b0, m_fire};
    end
  end

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge aclk) begin
    if (s_fire) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/axis_video_frame_checker.sv
// rtl/axis_video_frame_checker.sv - pass-through video stream checker measuring line and frame geometry
module axis_video_frame_checker
  import video_chk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_height,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_height,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_line_short,
  output logic              err_line_long,
  output logic              err_frame_short,
  output logic              err_no_sof,
  output logic [CNT_W-1:0]  frame_count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s_fire;
  chk_state_e       state, st_n;
  logic [CNT_W-1:0] pix_cnt, pix_n, line_cnt, line_n;
  logic [CNT_W-1:0] width_l, w_n, height_l, h_n;
  logic [CNT_W-1:0] mw_n, mh_n, fc_n, pix_inc, line_inc;
  logic             frame_bad, bad_n, done_n, ok_n;
  logic             ls_n, ll_n, fs_n, ns_n;

  axis_skid_buf #(.W(DATA_W + 2)) u_skid (
    .aclk     (aclk),
    .areset   (areset),
    .s_tdata  ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .s_tvalid (s_axis_tvalid),
    .s_tready (s_axis_tready),
    .m_tdata  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

  assign s_fire = s_axis_tvalid & s_axis_tready;

  // Beat-by-beat measurement: a premature SOF first closes the old frame, then starts the new one on the same beat.
  always_comb begin
    st_n     = state;
    pix_n    = pix_cnt;
    line_n   = line_cnt;
    w_n      = width_l;
    h_n      = height_l;
    bad_n    = frame_bad;
    mw_n     = meas_width;
    mh_n     = meas_height;
    fc_n     = frame_count;
    done_n   = 1'b0;
    ok_n     = frame_ok;
    ls_n     = err_line_short;
    ll_n     = err_line_long;
    fs_n     = err_frame_short;
    ns_n     = err_no_sof;
    pix_inc  = '0;
    line_inc = '0;
    if (s_fire) begin
      if (s_axis_tuser) begin
        if (state == IN_FRAME) begin
          done_n = 1'b1;
          mh_n   = line_cnt;
          fc_n   = fc_n + ONE;
          fs_n   = 1'b1;
          ok_n   = 1'b0;
        end
        w_n    = cfg_width;
        h_n    = cfg_height;
        pix_n  = '0;
        line_n = '0;
        bad_n  = 1'b0;
        st_n   = IN_FRAME;
      end
      if (st_n == WAIT_SOF) begin
        ns_n = 1'b1;
      end else begin
        pix_inc = (pix_n == '1) ? pix_n : pix_n + ONE;
        if (s_axis_tlast) begin
          mw_n = pix_inc;
          if (w_n != '0 && pix_inc < w_n) begin
            ls_n  = 1'b1;
            bad_n = 1'b1;
          end
          if (w_n != '0 && pix_inc > w_n) begin
            ll_n  = 1'b1;
            bad_n = 1'b1;
          end
          pix_n    = '0;
          line_inc = (line_n == '1) ? line_n : line_n + ONE;
          line_n   = line_inc;
          if (h_n != '0 && line_inc == h_n) begin
            done_n = 1'b1;
            mh_n   = line_inc;
            fc_n   = fc_n + ONE;
            ok_n   = ~bad_n;
            st_n   = WAIT_SOF;
          end
        end else begin
          pix_n = pix_inc;
          // The line already holds width beats and is still open, so it must end up too long.
          if (w_n != '0 && pix_inc == w_n) begin
            ll_n  = 1'b1;
            bad_n = 1'b1;
          end
        end
      end
    end
  end

  // State, counters and flags register; stickies only fall on reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= WAIT_SOF;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      width_l         <= '0;
      height_l        <= '0;
      frame_bad       <= 1'b0;
      meas_width      <= '0;
      meas_height     <= '0;
      frame_count     <= '0;
      frame_done      <= 1'b0;
      frame_ok        <= 1'b0;
      err_line_short  <= 1'b0;
      err_line_long   <= 1'b0;
      err_frame_short <= 1'b0;
      err_no_sof      <= 1'b0;
    end else begin
      state           <= st_n;
      pix_cnt         <= pix_n;
      line_cnt        <= line_n;
      width_l         <= w_n;
      height_l        <= h_n;
      frame_bad       <= bad_n;
      meas_width      <= mw_n;
      meas_height     <= mh_n;
      frame_count     <= fc_n;
      frame_done      <= done_n;
      frame_ok        <= ok_n;
      err_line_short  <= ls_n;
      err_line_long   <= ll_n;
      err_frame_short <= fs_n;
      err_no_sof      <= ns_n;
    end
  end

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// tb/tb_axis_video_frame_checker.sv - randomized self-checking bench for axis_video_frame_checker
module tb_axis_video_frame_checker;

  localparam int DW     = 24;
  localparam int CW     = 12;
  localparam int BUDGET = 30000;

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] w;
    logic [CW-1:0] h;
    logic          ok;
  } frame_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [CW-1:0] cfg_width, cfg_height, meas_width, meas_height, frame_count;
  logic          frame_done, frame_ok;
  logic          err_line_short, err_line_long, err_frame_short, err_no_sof;

  beat_t  stim[$];
  beat_t  exp_out[$];
  frame_t exp_frames[$];
  int     exp_fc;
  int     vectors;
  int     miscompares;
  bit     prev_stall;
  beat_t  prev_beat;

  always #5 aclk = ~aclk;

  axis_video_frame_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .meas_width      (meas_width),
    .meas_height     (meas_height),
    .frame_done      (frame_done),
    .frame_ok        (frame_ok),
    .err_line_short  (err_line_short),
    .err_line_long   (err_line_long),
    .err_frame_short (err_frame_short),
    .err_no_sof      (err_no_sof),
    .frame_count     (frame_count)
  );

  task automatic add_line(input int len, input bit sof);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'($urandom);
      b.user = sof && (i == 0);
      b.last = (i == len - 1);
      stim.push_back(b);
    end
  endtask

  task automatic add_frame(input int w, input int h);
    add_line(w, 1'b1);
    for (int i = 1; i < h; i++) add_line(w, 1'b0);
  endtask

  task automatic expect_frame(input int w, input int h, input bit ok);
    frame_t f;
    f.w  = CW'(w);
    f.h  = CW'(h);
    f.ok = ok;
    exp_frames.push_back(f);
    exp_fc++;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    stim.delete();
    exp_out.delete();
    exp_frames.delete();
    exp_fc     = 0;
    prev_stall = 1'b0;
  endtask

  // Drives the stimulus queue, scoreboards forwarded beats, stall stability and frame results.
  task automatic play(input bit gaps, input bit rnd, input int stop_after, output int cycles);
    int     acc;
    bit     fire;
    beat_t  ob;
    beat_t  cur;
    frame_t ef;
    acc    = 0;
    cycles = 0;
    forever begin
      if (stop_after >= 0 && acc >= stop_after) break;
      if (stop_after < 0 && stim.size() == 0 && exp_out.size() == 0) break;
      if (cycles >= BUDGET) begin
        vectors++;
        miscompares++;
        $display("FAIL play_timeout: cycles %0d, stim left %0d, out pending %0d", cycles, stim.size(), exp_out.size());
        break;
      end
      if (!s_axis_tvalid && stim.size() != 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
        s_axis_tdata  = stim[0].data;
        s_axis_tuser  = stim[0].user;
        s_axis_tlast  = stim[0].last;
        s_axis_tvalid = 1'b1;
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      fire = s_axis_tvalid && s_axis_tready;
      cur  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (prev_stall) begin
        vectors++;
        if ({m_axis_tvalid, cur} !== {1'b1, prev_beat}) begin
          miscompares++;
          $display("FAIL stall_hold: got valid %b beat %h, want valid 1 beat %h", m_axis_tvalid, cur, prev_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (exp_out.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got beat %h, want none", cur);
        end else begin
          ob = exp_out.pop_front();
          if (cur !== ob) begin
            miscompares++;
            $display("FAIL out_beat: got %h want %h", cur, ob);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
      if (frame_done) begin
        vectors++;
        if (exp_frames.size() == 0) begin
          miscompares++;
          $display("FAIL extra_frame_done: got w %0d h %0d ok %b, want no frame", meas_width, meas_height, frame_ok);
        end else begin
          ef = exp_frames.pop_front();
          if ({meas_width, meas_height, frame_ok} !== {ef.w, ef.h, ef.ok}) begin
            miscompares++;
            $display("FAIL frame_result: got w %0d h %0d ok %b, want w %0d h %0d ok %b",
                     meas_width, meas_height, frame_ok, ef.w, ef.h, ef.ok);
          end
        end
      end
      if (fire) exp_out.push_back(stim[0]);
      @(posedge aclk);
      #1;
      if (fire) begin
        stim.delete(0);
        s_axis_tvalid = 1'b0;
        acc++;
      end
      cycles++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    vectors++;
    if ({s_axis_tready, m_axis_tvalid, frame_done, frame_ok, err_line_short, err_line_long,
         err_frame_short, err_no_sof, meas_width, meas_height, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy %b vld %b done %b ok %b errs %b%b%b%b mw %0d mh %0d fc %0d, want all 0",
               s_axis_tready, m_axis_tvalid, frame_done, frame_ok, err_line_short, err_line_long,
               err_frame_short, err_no_sof, meas_width, meas_height, frame_count);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    vectors++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL ready_after_reset: got rdy %b vld %b, want rdy 1 vld 0", s_axis_tready, m_axis_tvalid);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_clean_frames();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    for (int f = 0; f < 4; f++) begin
      add_frame(8, 4);
      expect_frame(8, 4, 1'b1);
    end
    play(1'b0, 1'b0, -1, cyc);
    vectors++;
    if (exp_frames.size() != 0) begin
      miscompares++;
      $display("FAIL clean_frames_missing: got %0d frames outstanding, want 0", exp_frames.size());
    end
    vectors++;
    if (frame_count !== CW'(exp_fc)) begin
      miscompares++;
      $display("FAIL clean_frame_count: got %0d want %0d", frame_count, exp_fc);
    end
    vectors++;
    if ({err_line_short, err_line_long, err_frame_short, err_no_sof} !== 4'b0000) begin
      miscompares++;
      $display("FAIL clean_flags: got %b%b%b%b want 0000", err_line_short, err_line_long, err_frame_short, err_no_sof);
    end
    vectors++;
    if (cyc > 128 + 3) begin
      miscompares++;
      $display("FAIL throughput: got %0d cycles for 128 beats, want at most 131", cyc);
    end
  endtask

  task automatic test_line_short();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    expect_frame(8, 4, 1'b0);
    expect_frame(8, 4, 1'b1);
    add_line(8, 1'b1);
    add_line(6, 1'b0);
    play(1'b1, 1'b1, -1, cyc);
    vectors++;
    if ({meas_width, err_line_short} !== {12'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL short_line_meas: got mw %0d short %b, want mw 6 short 1", meas_width, err_line_short);
    end
    add_line(8, 1'b0);
    add_line(8, 1'b0);
    add_frame(8, 4);
    play(1'b1, 1'b1, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, frame_count, err_line_long} !== {1'b1, CW'(exp_fc), 1'b0}) begin
      miscompares++;
      $display("FAIL short_line_end: got outstanding %0d fc %0d long %b, want 0 %0d 0",
               exp_frames.size(), frame_count, err_line_long, exp_fc);
    end
  endtask

  task automatic test_line_long();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    add_line(8, 1'b1);
    add_line(10, 1'b0);
    add_line(8, 1'b0);
    add_line(8, 1'b0);
    expect_frame(8, 4, 1'b0);
    add_frame(8, 4);
    expect_frame(8, 4, 1'b1);
    play(1'b0, 1'b1, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, err_line_long, err_line_short} !== 3'b110) begin
      miscompares++;
      $display("FAIL long_line: got done-all %b long %b short %b, want 1 1 0",
               exp_frames.size() == 0, err_line_long, err_line_short);
    end
  endtask

  task automatic test_premature_sof();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    add_line(8, 1'b1);
    add_line(8, 1'b0);
    expect_frame(8, 2, 1'b0);
    add_frame(8, 4);
    expect_frame(8, 4, 1'b1);
    play(1'b1, 1'b0, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, err_frame_short, err_line_short, err_line_long, frame_count}
        !== {1'b1, 1'b1, 1'b0, 1'b0, CW'(exp_fc)}) begin
      miscompares++;
      $display("FAIL premature_sof: got done-all %b fshort %b short %b long %b fc %0d, want 1 1 0 0 %0d",
               exp_frames.size() == 0, err_frame_short, err_line_short, err_line_long, frame_count, exp_fc);
    end
  endtask

  task automatic test_random_stall();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    for (int f = 0; f < 4; f++) begin
      add_frame(8, 4);
      expect_frame(8, 4, 1'b1);
    end
    play(1'b1, 1'b1, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, frame_count, err_line_short, err_line_long, err_frame_short, err_no_sof}
        !== {1'b1, 12'd4, 4'b0000}) begin
      miscompares++;
      $display("FAIL random_stall: got done-all %b fc %0d flags %b%b%b%b, want 1 4 0000",
               exp_frames.size() == 0, frame_count, err_line_short, err_line_long, err_frame_short, err_no_sof);
    end
  endtask

  task automatic test_no_sof();
    int cyc;
    do_reset();
    cfg_width  = 12'd8;
    cfg_height = 12'd4;
    add_line(3, 1'b0);
    stim[2].last = 1'b0;
    add_frame(8, 4);
    expect_frame(8, 4, 1'b1);
    play(1'b1, 1'b1, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, err_no_sof, frame_count} !== {1'b1, 1'b1, 12'd1}) begin
      miscompares++;
      $display("FAIL no_sof: got done-all %b nosof %b fc %0d, want 1 1 1",
               exp_frames.size() == 0, err_no_sof, frame_count);
    end
  endtask

  task automatic test_wide_frame_and_reset();
    int cyc;
    do_reset();
    cfg_width  = 12'd800;
    cfg_height = 12'd12;
    add_frame(800, 12);
    expect_frame(800, 12, 1'b1);
    play(1'b0, 1'b0, -1, cyc);
    vectors++;
    if ({exp_frames.size() == 0, meas_width, meas_height, frame_ok} !== {1'b1, 12'd800, 12'd12, 1'b1}) begin
      miscompares++;
      $display("FAIL wide_frame: got done-all %b mw %0d mh %0d ok %b, want 1 800 12 1",
               exp_frames.size() == 0, meas_width, meas_height, frame_ok);
    end
    add_frame(800, 12);
    play(1'b0, 1'b1, 400, cyc);
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    vectors++;
    if ({s_axis_tready, m_axis_tvalid, frame_done, frame_ok, err_line_short, err_line_long,
         err_frame_short, err_no_sof, meas_width, meas_height, frame_count} !== '0) begin
      miscompares++;
      $display("FAIL midline_reset: got rdy %b vld %b done %b ok %b mw %0d mh %0d fc %0d, want all 0",
               s_axis_tready, m_axis_tvalid, frame_done, frame_ok, meas_width, meas_height, frame_count);
    end
    do_reset();
    add_line(1, 1'b0);
    stim[0].last = 1'b0;
    play(1'b0, 1'b0, -1, cyc);
    vectors++;
    if ({err_no_sof, frame_count} !== {1'b1, 12'd0}) begin
      miscompares++;
      $display("FAIL post_reset_no_sof: got nosof %b fc %0d, want 1 0", err_no_sof, frame_count);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_fc        = 0;
    prev_stall    = 1'b0;
    prev_beat     = '0;
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    cfg_width     = 12'd8;
    cfg_height    = 12'd4;
    test_reset();
    test_clean_frames();
    test_line_short();
    test_line_long();
    test_premature_sof();
    test_random_stall();
    test_no_sof();
    test_wide_frame_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
